abc_operand_loader: RTL and testbench
=====================================

// Module: abc_operand_loader
// PURPOSE
//  Upstream feeder for the sample datapath. Assembles a byte stream into one {a,b,c} operand frame.
//  Holds the frame stable on 8-bit outputs a/b/c until the consumer accepts it.
//  Sits between the byte-stream source and the sample block's a/b/c inputs. Also counts delivered frames.
// PARAMETERS
//  DATA_W   8    width of each byte and of a/b/c
//  CNT_W    16   width of frame_cnt; wraps modulo 2**CNT_W
// PORTS
//  clk        in   1       clock; all logic rising-edge
//  rst_n      in   1       reset, asynchronous, active-low
//  in_data    in   DATA_W  stream byte
//  in_valid   in   1       in_data valid
//  in_sof     in   1       qualifies in_data as first byte of a frame (resync)
//  in_ready   out  1       loader can take a byte this cycle
//  a,b,c      out  DATA_W  operand frame; stable while abc_valid=1
//  abc_valid  out  1       frame available
//  abc_ready  in   1       consumer accepts frame
//  frame_cnt  out  CNT_W   frames delivered (handshakes completed)
//  err        out  1       1-cycle pulse on frame discard
// BEHAVIOUR
//  Byte accepted when in_valid & in_ready; handoff when abc_valid & abc_ready.
//  Reset: state=IDLE, a=b=c=0, abc_valid=0, in_ready=1, frame_cnt=0, err=0.
//  FSM states: IDLE, GOT_A, GOT_B, [GOT_C], HOLD.
//   IDLE: accepted byte with in_sof=1 -> a, goto GOT_A. Byte without in_sof is dropped; no err.
//   GOT_A: byte -> b, goto GOT_B.
//   GOT_B: byte -> c, goto HOLD (or GOT_C if CHECKSUM_EN).
//   HOLD: abc_valid=1, in_ready=0. Handoff -> frame_cnt+1, goto IDLE.
//  Resync: in_sof=1 on an accepted byte in GOT_A/GOT_B/GOT_C discards the partial frame.
//   That byte becomes the new a; goto GOT_A; err pulses.
//  Latency: abc_valid rises the cycle after the final byte is accepted.
//   Earliest next-frame byte is accepted the cycle after handoff (3 bytes + 1 hold min per frame).
//  a/b/c are registered; they change only on their own load. Never change while abc_valid=1.
//  abc_valid drops the cycle after handoff. abc_ready while abc_valid=0 has no effect.
//  frame_cnt wraps all-ones -> 0 silently.
//  Reset mid-frame or mid-HOLD: immediate return to reset values; partial frame lost; no err.
// CONFIGURATION
//  CHECKSUM_EN defined: a fourth byte is expected in state GOT_C.
//   If it equals a^b^c -> HOLD. Otherwise frame discarded, err pulses, goto IDLE, frame_cnt unchanged.
//   in_sof on the checksum byte is treated as resync (see above).
//  CHECKSUM_EN undefined: GOT_C and the compare logic are absent; GOT_B goes straight to HOLD.
//   err fires only on resync.
// STRUCTURE
//  Shared package abc_pkg: state encoding localparams, ABC_FRAME_LEN (3, or 4 with CHECKSUM_EN), DATA_W default.
//  One sub-module: abc_frame_counter (CNT_W wrap counter, inc on handoff).
//  FSM and a/b/c registers stay in this module.
// TESTING
//  Bytes 0x11(sof),0x22,0x33, abc_ready=1 -> a/b/c=11/22/33, abc_valid 1 cycle, frame_cnt=1.
//  Same frame, abc_ready held 0 for 5 cycles -> in_ready=0, a/b/c stable, then 1 handoff, frame_cnt=1.
//  0x11(sof),0x22,0x44(sof),0x55,0x66 -> err pulse at 0x44; frame 44/55/66 delivered; 11/22 never seen.
//  CHECKSUM_EN: 01,02,03,00 -> delivered; 01,02,03,FF -> err, no abc_valid, frame_cnt unchanged.
//  CNT_W=4, 17 back-to-back frames -> frame_cnt sequence wraps 15->0, final value 1.
//  rst_n low during GOT_B and again during HOLD -> outputs at reset values; next frame delivers normally.

Source files
------------

// File: rtl/abc_pkg.sv
// abc_pkg: shared state encoding, frame length and default width for the a/b/c operand loader.
// CHECKSUM_EN adds the GOT_C state and a fourth (checksum) byte per frame.
package abc_pkg;
    localparam int ABC_DATA_W = 8;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GOT_A = 3'd1;
    localparam logic [2:0] ST_GOT_B = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd4;
`ifdef CHECKSUM_EN
    localparam logic [2:0] ST_GOT_C = 3'd3;
    localparam int ABC_FRAME_LEN = 4;
    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        GOT_A = ST_GOT_A,
        GOT_B = ST_GOT_B,
        GOT_C = ST_GOT_C,
        HOLD  = ST_HOLD
    } state_t;
`else
    localparam int ABC_FRAME_LEN = 3;
    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        GOT_A = ST_GOT_A,
        GOT_B = ST_GOT_B,
        HOLD  = ST_HOLD
    } state_t;
`endif
endpackage

// File: rtl/abc_frame_counter.sv
// abc_frame_counter: counts completed frame handoffs, wrapping modulo 2**CNT_W.
module abc_frame_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
endmodule

// File: rtl/abc_operand_loader.sv
// abc_operand_loader: assembles a byte stream into a held {a,b,c} frame and counts handoffs.
// Define CHECKSUM_EN to require a fourth byte equal to a^b^c before the frame is offered.
module abc_operand_loader
    import abc_pkg::*;
#(
    parameter int DATA_W = ABC_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic              abc_valid,
    input  logic              abc_ready,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              err
);
    state_t state;
    logic   take;
    logic   handoff;

    assign take    = in_valid & in_ready;
    assign handoff = abc_valid & abc_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            abc_valid <= 1'b0;
            in_ready  <= 1'b1;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (take) begin
                // an SOF byte anywhere restarts the frame; mid-frame it also flags the discard
                if (in_sof) begin
                    a     <= in_data;
                    state <= GOT_A;
                    err   <= (state != IDLE);
                end else begin
                    case (state)
                        GOT_A: begin
                            b     <= in_data;
                            state <= GOT_B;
                        end
                        GOT_B: begin
                            c <= in_data;
`ifdef CHECKSUM_EN
                            state <= GOT_C;
`else
                            state     <= HOLD;
                            abc_valid <= 1'b1;
                            in_ready  <= 1'b0;
`endif
                        end
`ifdef CHECKSUM_EN
                        GOT_C: begin
                            if (in_data == (a ^ b ^ c)) begin
                                state     <= HOLD;
                                abc_valid <= 1'b1;
                                in_ready  <= 1'b0;
                            end else begin
                                state <= IDLE;
                                err   <= 1'b1;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
            if (handoff) begin
                state     <= IDLE;
                abc_valid <= 1'b0;
                in_ready  <= 1'b1;
            end
        end
    end

    abc_frame_counter #(.CNT_W(CNT_W)) u_frame_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (handoff),
        .cnt   (frame_cnt)
    );
endmodule

// File: tb/tb_abc_operand_loader.sv
// tb_abc_operand_loader: directed and random byte streams checked every cycle against a
// queue-based frame model; CHECKSUM_EN selects the four-byte frame variant.
module tb_abc_operand_loader;
    localparam int DW = 8;
    localparam int CW = 4;
`ifdef CHECKSUM_EN
    localparam int FLEN = 4;
`else
    localparam int FLEN = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a, b, c;
    logic          abc_valid;
    logic          abc_ready = 1'b0;
    logic [CW-1:0] frame_cnt;
    logic          err;

    abc_operand_loader #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .abc_valid (abc_valid),
        .abc_ready (abc_ready),
        .frame_cnt (frame_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    bit [7:0] part[$];
    bit       holding, exp_err;
    bit [7:0] ra, rb, rc;
    int       cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        part.delete();
        holding = 0;
        exp_err = 0;
        ra = 0;
        rb = 0;
        rc = 0;
        cnt = 0;
    endfunction

    function automatic void model_edge();
        bit pushed;
        if (!rst_n) return;
        exp_err = 0;
        pushed = 0;
        if (holding) begin
            if (abc_ready) begin
                holding = 0;
                cnt = (cnt + 1) % (1 << CW);
            end
        end else if (in_valid) begin
            if (in_sof) begin
                if (part.size() != 0) exp_err = 1;
                part.delete();
                part.push_back(in_data);
                pushed = 1;
            end else if (part.size() != 0) begin
                part.push_back(in_data);
                pushed = 1;
            end
            if (pushed) begin
                if (part.size() == 1) ra = in_data;
                if (part.size() == 2) rb = in_data;
                if (part.size() == 3) rc = in_data;
            end
            if (part.size() == FLEN) begin
`ifdef CHECKSUM_EN
                if (part[3] == (part[0] ^ part[1] ^ part[2])) holding = 1;
                else exp_err = 1;
`else
                holding = 1;
`endif
                part.delete();
            end
        end
    endfunction

    task automatic compare();
        check("in_ready", in_ready, !holding);
        check("abc_valid", abc_valid, holding);
        check("a", a, ra);
        check("b", b, rb);
        check("c", c, rc);
        check("err", err, exp_err);
        check("frame_cnt", frame_cnt, cnt);
    endtask

    task automatic step(input bit v, input bit s, input bit [7:0] d, input bit r);
        @(negedge clk);
        compare();
        in_valid = v;
        in_sof = s;
        in_data = d;
        abc_ready = r;
        @(posedge clk);
        model_edge();
    endtask

    task automatic send_frame(input bit [7:0] x, input bit [7:0] y, input bit [7:0] z, input bit r);
        step(1, 1, x, r);
        step(1, 0, y, r);
        step(1, 0, z, r);
`ifdef CHECKSUM_EN
        step(1, 0, x ^ y ^ z, r);
`endif
    endtask

    task automatic async_reset();
        @(negedge clk);
        compare();
        in_valid = 0;
        in_sof = 0;
        abc_ready = 0;
        #2 rst_n = 0;
        model_reset();
        #1 compare();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        bit       v, s, r;
        bit [7:0] d;
        #1 rst_n = 0;
        model_reset();
        #1 compare();
        repeat (2) @(negedge clk);
        rst_n = 1;

        send_frame(8'h11, 8'h22, 8'h33, 1);
        step(0, 0, 0, 1);
        check("a_first", a, 8'h11);
        check("c_first", c, 8'h33);
        step(0, 0, 0, 1);
        check("cnt_first", frame_cnt, 1);

        send_frame(8'h11, 8'h22, 8'h33, 0);
        repeat (5) step(1, 0, 8'h99, 0);
        check("ready_low_hold", in_ready, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("cnt_hold", frame_cnt, 2);

        step(1, 1, 8'h11, 1);
        step(1, 0, 8'h22, 1);
        step(1, 1, 8'h44, 1);
        step(1, 0, 8'h55, 1);
        step(1, 0, 8'h66, 1);
`ifdef CHECKSUM_EN
        step(1, 0, 8'h77, 1);
`endif
        step(0, 0, 0, 1);
        check("a_resync", a, 8'h44);
        step(0, 0, 0, 1);

`ifdef CHECKSUM_EN
        step(1, 1, 8'h01, 1);
        step(1, 0, 8'h02, 1);
        step(1, 0, 8'h03, 1);
        step(1, 0, 8'h00, 1);
        step(0, 0, 0, 1);
        step(1, 1, 8'h01, 1);
        step(1, 0, 8'h02, 1);
        step(1, 0, 8'h03, 1);
        step(1, 0, 8'hFF, 1);
        step(0, 0, 0, 1);
        check("csum_bad_err", err, 1);
        step(0, 0, 0, 1);
`endif

        async_reset();
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 8'(i + 1), 8'(i + 2), 1);
            step(0, 0, 0, 1);
        end
        step(0, 0, 0, 0);
        check("cnt_wrap", frame_cnt, 1);

        step(1, 1, 8'hA1, 0);
        step(1, 0, 8'hA2, 0);
        async_reset();
        check("rst_gotb_a", a, 0);
        send_frame(8'h31, 8'h32, 8'h33, 0);
        step(0, 0, 0, 0);
        async_reset();
        check("rst_hold_valid", abc_valid, 0);
        send_frame(8'h41, 8'h42, 8'h43, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("after_rst_cnt", frame_cnt, 1);

        for (int i = 0; i < 3000; i++) begin
            v = $urandom_range(0, 9) < 7;
            s = $urandom_range(0, 9) < 2;
            d = 8'($urandom);
            r = $urandom_range(0, 1) == 1;
            if (FLEN == 4 && part.size() == 3 && !s && $urandom_range(0, 1) == 1)
                d = part[0] ^ part[1] ^ part[2];
            step(v, s, d, r);
        end
        @(negedge clk);
        compare();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
